q5_vector_player: RTL and testbench



---
 rtl/q5_pkg.sv | 24 ++
 rtl/q5_vec_rom.sv | 15 +
 rtl/q5_vector_player.sv | 133 +++++++++++++
 tb/tb_q5_vector_player.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/q5_pkg.sv
// Shared definitions for the Q5 vector player: FSM states, vector table, ROM word.
package q5_pkg;

    localparam int Q5_NUM_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } q5_state_t;

    // Stimulus {X1,X2} and expected response {Z1,Z2} for each table entry
    localparam logic [1:0] Q5_STIM [0:7] = '{2'b00, 2'b01, 2'b11, 2'b01,
                                             2'b00, 2'b10, 2'b11, 2'b01};
    localparam logic [1:0] Q5_EXP  [0:7] = '{2'b00, 2'b00, 2'b11, 2'b10,
                                             2'b10, 2'b01, 2'b00, 2'b00};

    typedef struct packed {
        logic [1:0] stim;
        logic [1:0] exp;
    } q5_vec_t;

endpackage

// File: rtl/q5_vec_rom.sv
// Combinational vector table lookup: index -> {stimulus, expected response}.
module q5_vec_rom
    import q5_pkg::*;
(
    input  logic [2:0] i_idx,
    output q5_vec_t    o_vec
);

    // Pure table read, no state
    always_comb begin
        o_vec.stim = Q5_STIM[i_idx];
        o_vec.exp  = Q5_EXP[i_idx];
    end

endmodule

// File: rtl/q5_vector_player.sv
// Q5 vector player: drives X1/X2 from the vector table, samples Z1/Z2 after a
// settle window, counts mismatches and reports done/pass.
// Optional build macro Q5_PLAYER_STOP_ON_ERR_EN: stop at the first mismatch.
module q5_vector_player
    import q5_pkg::*;
#(
    parameter int NUM_VEC       = Q5_NUM_VEC,
    parameter int SETTLE_CYCLES = 4,
    parameter int RUNS          = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       X1,
    output logic       X2,
    input  logic       Z1,
    input  logic       Z2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] vec_idx
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RW = (RUNS > 1) ? $clog2(RUNS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUNS - 1);
    localparam logic [2:0]    VEC_LAST = 3'(NUM_VEC - 1);

`ifdef Q5_PLAYER_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    q5_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_run;
    logic [2:0]    r_vec_idx;
    logic [1:0]    r_x;
    logic [1:0]    r_exp;
    logic [7:0]    r_err;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic [2:0]    w_nxt_idx;
    logic [2:0]    w_ld_idx;
    q5_vec_t       w_ld;
    logic          w_mis;
    logic          w_last;
    logic [7:0]    w_err_nxt;

    // The ROM is addressed by the vector about to be loaded; its expected
    // response is latched alongside X1/X2 so the compare needs no second lookup.
    assign w_nxt_idx = (r_vec_idx == VEC_LAST) ? 3'd0 : r_vec_idx + 3'd1;
    assign w_ld_idx  = (r_state == ST_SAMPLE) ? w_nxt_idx : 3'd0;

    q5_vec_rom u_rom (
        .i_idx (w_ld_idx),
        .o_vec (w_ld)
    );

    assign w_mis     = ({Z1, Z2} != r_exp);
    assign w_err_nxt = (w_mis && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
    assign w_last    = (r_vec_idx == VEC_LAST) && (r_run == RUN_LAST);

    // Sequencer: load vector, settle, sample/compare, advance or finish
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_run     <= '0;
            r_vec_idx <= '0;
            r_x       <= '0;
            r_exp     <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_SETTLE;
                        r_cnt     <= '0;
                        r_run     <= '0;
                        r_vec_idx <= '0;
                        r_err     <= '0;
                        r_x       <= w_ld.stim;
                        r_exp     <= w_ld.exp;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_LAST) r_state <= ST_SAMPLE;
                    else                   r_cnt   <= r_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    r_err <= w_err_nxt;
                    if (w_last || (STOP_ON_ERR && w_mis)) begin
                        // X1/X2 and vec_idx stay on the final/failing vector
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == 8'd0);
                    end else begin
                        r_state   <= ST_SETTLE;
                        r_cnt     <= '0;
                        r_vec_idx <= w_nxt_idx;
                        r_x       <= w_ld.stim;
                        r_exp     <= w_ld.exp;
                        if (r_vec_idx == VEC_LAST) r_run <= r_run + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign X1        = r_x[1];
    assign X2        = r_x[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_q5_vector_player.sv
// Self-checking bench for q5_vector_player: table of response modes plus
// random responses scored by a timeline-based reference model, and
// hand-written reset-abort and restart sequences.
module tb_q5_vector_player;

`ifdef Q5_PLAYER_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int SETTLE = 4;
    localparam int TOTAL  = 2 * 8 * (SETTLE + 1);  // 80 cycles per sequence

    localparam int M_CORRECT = 0;
    localparam int M_ZERO    = 1;
    localparam int M_SWAP    = 2;
    localparam int M_RANDOM  = 3;

    logic       clk = 1'b0;
    logic       rst, start, Z1, Z2;
    logic       X1, X2, busy, done, pass;
    logic [7:0] err_count;
    logic [2:0] vec_idx;

    int errs   = 0;
    int checks = 0;

    logic [1:0] T_STIM [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] T_EXP  [8] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};

    typedef struct {
        int mode;
        int restart_at;  // cycle of a start pulse while busy, 0 = none
        int exp_err;     // -1: take it from the reference model
        int exp_idx;     // -1: take it from the reference model
    } vec_t;

    vec_t tbl [6];

    q5_vector_player dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X1        (X1),
        .X2        (X2),
        .Z1        (Z1),
        .Z2        (Z2),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_idx   (vec_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response of the attached (possibly faulty) Q5 model for table entry idx
    function automatic logic [1:0] resp(input int mode, input int idx);
        logic [1:0] e;
        e = T_EXP[idx];
        case (mode)
            M_CORRECT: return e;
            M_ZERO:    return 2'b00;
            M_SWAP:    return {e[0], e[1]};
            default:   return 2'($urandom_range(0, 3));
        endcase
    endfunction

    // One full sequence; vector v is sampled on the edge start+5v+5
    task automatic run_seq(input int mode, input int restart_at,
                           input int exp_err, input int exp_idx);
        int         m_err, fin_idx, idx, e_err, e_idx;
        bit         stopped, samp;
        logic [1:0] z;
        m_err = 0; fin_idx = 7; stopped = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_err", err_count, 0);
        chk("start_vec", vec_idx, 0);
        for (int t = 1; t <= TOTAL && !stopped; t++) begin
            idx  = ((t - 1) / 5) % 8;
            samp = (t % 5 == 0);
            if (samp) begin
                z = resp(mode, idx);
                chk("drive_x", {X1, X2}, T_STIM[idx]);
                chk("drive_idx", vec_idx, idx);
            end else begin
                z = 2'($urandom_range(0, 3));  // glitches during settle
            end
            {Z1, Z2} = z;
            start = (t == restart_at);
            @(negedge clk);
            if (samp && z != T_EXP[idx]) begin
                m_err++;
                if (STOP) begin stopped = 1; fin_idx = idx; end
            end
            if (!stopped && t < TOTAL) begin
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
            end
        end
        start = 1'b0;
        e_err = (exp_err < 0) ? m_err : exp_err;
        e_idx = (exp_idx < 0) ? fin_idx : exp_idx;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_err", err_count, e_err);
        chk("end_pass", pass, (e_err == 0) ? 1 : 0);
        chk("end_idx", vec_idx, e_idx);
        chk("end_x", {X1, X2}, T_STIM[e_idx]);
        @(negedge clk);
        chk("hold_done", done, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, {X1, X2}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_idx"}, vec_idx, 0);
    endtask

    initial begin
        tbl[0] = '{M_CORRECT, 0,  0,                   7};
        tbl[1] = '{M_ZERO,    0,  STOP ? 1 : 8,        STOP ? 2 : 7};
        tbl[2] = '{M_SWAP,    0,  STOP ? 1 : 6,        STOP ? 3 : 7};
        tbl[3] = '{M_CORRECT, 20, 0,                   7};
        tbl[4] = '{M_RANDOM,  0,  -1,                  -1};
        tbl[5] = '{M_RANDOM,  0,  -1,                  -1};

        rst = 1'b1; start = 1'b0; Z1 = 1'b0; Z2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        foreach (tbl[i]) run_seq(tbl[i].mode, tbl[i].restart_at, tbl[i].exp_err, tbl[i].exp_idx);

        // Abort with rst at cycle 30 of a sequence with Z tied low
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        {Z1, Z2} = 2'b00;
        repeat (30) @(negedge clk);
        chk("pre_rst_err", err_count, STOP ? 1 : 4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_reset_vals("abort");
        repeat (3) @(negedge clk);
        chk("abort_idle", busy, 0);
        run_seq(M_CORRECT, 0, 0, 7);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
